// File: rtl/si5340_cfg_sequencer.sv
// rtl/si5340_cfg_sequencer.sv - walks the Si5340 config ROM and issues one I2C register write per entry,
// inserting page-select writes and the post-preamble pause.
module si5340_cfg_sequencer #(
  parameter int         MEM_DEPTH    = 326,
  parameter int         MEM_WIDTH    = 24,
  parameter int         DATA_WIDTH   = 8,
  parameter logic [6:0] SLAVE_ADDR   = 7'b111_0100,
  parameter int         PAUSE_IDX    = 2,
  parameter int         PAUSE_CYCLES = 37_500_000,
  localparam int        IDX_W        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  start_i,
  output logic                  mem_rd_o,
  output logic [IDX_W-1:0]      mem_addr_o,
  input  logic [MEM_WIDTH-1:0]  mem_data_i,
  output logic                  txn_valid_o,
  input  logic                  txn_ready_i,
  output logic [6:0]            txn_addr_o,
  output logic [DATA_WIDTH-1:0] txn_reg_o,
  output logic [DATA_WIDTH-1:0] txn_data_o,
  input  logic                  txn_done_i,
  input  logic                  txn_nack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [IDX_W-1:0]      err_idx_o
);

  localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_LATCH, S_PAGE_REQ, S_PAGE_WAIT, S_WR_REQ,
    S_WR_WAIT, S_PAUSE, S_NEXT, S_DONE, S_ERROR
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [MEM_WIDTH-1:0]    entry_q;
  logic [DATA_WIDTH-1:0]   cur_page_q;
  logic                    page_valid_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    mem_rd_q, txn_valid_q, busy_q, done_q, err_q;
  logic [6:0]              txn_addr_q;
  logic [DATA_WIDTH-1:0]   txn_reg_q, txn_data_q;
  logic [IDX_W-1:0]        err_idx_q;

  logic [DATA_WIDTH-1:0] rom_page, rom_reg, rom_dat;
  logic [DATA_WIDTH-1:0] ent_page, ent_reg, ent_dat;

  assign rom_page = mem_data_i[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign rom_reg  = mem_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
  assign rom_dat  = mem_data_i[DATA_WIDTH-1:0];
  assign ent_page = entry_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign ent_reg  = entry_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign ent_dat  = entry_q[DATA_WIDTH-1:0];

  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = idx_q;
  assign txn_valid_o = txn_valid_q;
  assign txn_addr_o  = txn_addr_q;
  assign txn_reg_o   = txn_reg_q;
  assign txn_data_o  = txn_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_idx_o   = err_idx_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      entry_q      <= '0;
      cur_page_q   <= '0;
      page_valid_q <= 1'b0;
      cnt_q        <= '0;
      mem_rd_q     <= 1'b0;
      txn_valid_q  <= 1'b0;
      txn_addr_q   <= '0;
      txn_reg_q    <= '0;
      txn_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_idx_q    <= '0;
    end else begin
      mem_rd_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state_q      <= S_READ;
            idx_q        <= '0;
            page_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_idx_q    <= '0;
            busy_q       <= 1'b1;
            mem_rd_q     <= 1'b1;
          end
        end
        S_READ: state_q <= S_LATCH;
        S_LATCH: begin
          entry_q     <= mem_data_i;
          txn_valid_q <= 1'b1;
          txn_addr_q  <= SLAVE_ADDR;
          if (!page_valid_q || rom_page != cur_page_q) begin
            txn_reg_q  <= DATA_WIDTH'(1);
            txn_data_q <= rom_page;
            state_q    <= S_PAGE_REQ;
          end else begin
            txn_reg_q  <= rom_reg;
            txn_data_q <= rom_dat;
            state_q    <= S_WR_REQ;
          end
        end
        S_PAGE_REQ: begin
          if (txn_ready_i) begin
            txn_valid_q <= 1'b0;
            state_q     <= S_PAGE_WAIT;
          end
        end
        S_WR_REQ: begin
          if (txn_ready_i) begin
            txn_valid_q <= 1'b0;
            state_q     <= S_WR_WAIT;
          end
        end
        S_PAGE_WAIT: begin
          if (txn_done_i) begin
            if (txn_nack_i) begin
              state_q      <= S_ERROR;
              err_q        <= 1'b1;
              err_idx_q    <= idx_q;
              page_valid_q <= 1'b0;
              busy_q       <= 1'b0;
            end else begin
              cur_page_q   <= ent_page;
              page_valid_q <= 1'b1;
              txn_valid_q  <= 1'b1;
              txn_reg_q    <= ent_reg;
              txn_data_q   <= ent_dat;
              state_q      <= S_WR_REQ;
            end
          end
        end
        S_WR_WAIT: begin
          if (txn_done_i) begin
            if (txn_nack_i) begin
              state_q      <= S_ERROR;
              err_q        <= 1'b1;
              err_idx_q    <= idx_q;
              page_valid_q <= 1'b0;
              busy_q       <= 1'b0;
            end else if (idx_q == IDX_W'(PAUSE_IDX)) begin
              cnt_q   <= CNT_W'(PAUSE_CYCLES - 1);
              state_q <= S_PAUSE;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        // Counter runs PAUSE_CYCLES-1 down to 0, so the pause lasts exactly PAUSE_CYCLES cycles.
        S_PAUSE: begin
          if (cnt_q == '0) state_q <= S_NEXT;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_NEXT: begin
          if (idx_q == IDX_W'(MEM_DEPTH - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q    <= idx_q + 1'b1;
            mem_rd_q <= 1'b1;
            state_q  <= S_READ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
// tb/tb_si5340_cfg_sequencer.sv - scoreboard bench for the Si5340 config sequencer with ROM and I2C master models.
module tb_si5340_cfg_sequencer;

  localparam int MEM_DEPTH    = 4;
  localparam int PAUSE_IDX    = 1;
  localparam int PAUSE_CYCLES = 10;

  logic        clk = 1'b0;
  logic        arstn_i, start_i;
  logic        mem_rd_o;
  logic [1:0]  mem_addr_o;
  logic [23:0] mem_data_i;
  logic        txn_valid_o, txn_ready_i;
  logic [6:0]  txn_addr_o;
  logic [7:0]  txn_reg_o, txn_data_o;
  logic        txn_done_i, txn_nack_i;
  logic        busy_o, done_o, err_o;
  logic [1:0]  err_idx_o;

  always #4 clk = ~clk;

  si5340_cfg_sequencer #(
    .MEM_DEPTH(MEM_DEPTH), .MEM_WIDTH(24), .DATA_WIDTH(8), .SLAVE_ADDR(7'b111_0100),
    .PAUSE_IDX(PAUSE_IDX), .PAUSE_CYCLES(PAUSE_CYCLES)
  ) dut (
    .clk_i(clk), .arstn_i(arstn_i), .start_i(start_i),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .txn_valid_o(txn_valid_o), .txn_ready_i(txn_ready_i), .txn_addr_o(txn_addr_o),
    .txn_reg_o(txn_reg_o), .txn_data_o(txn_data_o), .txn_done_i(txn_done_i),
    .txn_nack_i(txn_nack_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_idx_o(err_idx_o)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int acc_cnt = 0;
  logic [15:0] last_acc = '0;
  logic [22:0] exp_q[$];

  logic [23:0] rom [0:3];
  initial begin
    rom[0] = 24'h000B24;
    rom[1] = 24'h000C00;
    rom[2] = 24'h051A3F;
    rom[3] = 24'h051B40;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_data_i <= rom[mem_addr_o];

  int          ready_delay = 0;
  logic        nack_en = 1'b0;
  logic [15:0] nack_match = '0;
  int          wait_cnt, done_cnt;
  logic        done_nack, model_done, model_nack;
  logic        stray_done = 1'b0, stray_nack = 1'b0;

  assign txn_done_i = model_done | stray_done;
  assign txn_nack_i = model_nack | stray_nack;

  // I2C master model: accepts after ready_delay cycles, completes 3 cycles after acceptance.
  always @(posedge clk or negedge arstn_i) begin
    if (!arstn_i) begin
      txn_ready_i <= 1'b0;
      wait_cnt    <= 0;
      done_cnt    <= 0;
      done_nack   <= 1'b0;
      model_done  <= 1'b0;
      model_nack  <= 1'b0;
    end else begin
      model_done <= 1'b0;
      model_nack <= 1'b0;
      if (done_cnt == 1) begin
        model_done <= 1'b1;
        model_nack <= done_nack;
      end
      if (done_cnt > 0) done_cnt <= done_cnt - 1;
      if (txn_valid_o && txn_ready_i) begin
        txn_ready_i <= 1'b0;
        wait_cnt    <= 0;
        done_cnt    <= 3;
        done_nack   <= nack_en && ({txn_reg_o, txn_data_o} == nack_match);
      end else if (txn_valid_o) begin
        if (wait_cnt >= ready_delay) txn_ready_i <= 1'b1;
        else                         wait_cnt    <= wait_cnt + 1;
      end
    end
  end

  // Transaction monitor: stability while stalled, scoreboard compare on acceptance.
  logic        pend = 1'b0;
  logic [22:0] held, cur, e;
  initial begin
    forever begin
      @(negedge clk);
      if (!arstn_i) begin
        pend = 1'b0;
      end else if (txn_valid_o) begin
        cur = {txn_addr_o, txn_reg_o, txn_data_o};
        if (!pend) begin
          pend = 1'b1;
          held = cur;
        end else begin
          tests_run++;
          if (cur !== held) begin
            tests_failed++;
            $display("FAIL txn_stable: got %h required %h", cur, held);
          end
        end
        if (txn_ready_i) begin
          pend = 1'b0;
          acc_cnt++;
          last_acc = cur[15:0];
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL txn_unexpected: got %h required none", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              tests_failed++;
              $display("FAIL txn_order: got %h required %h", cur, e);
            end
          end
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic push_seq(input int n);
    logic [15:0] seq [0:5];
    seq[0] = 16'h0100; seq[1] = 16'h0B24; seq[2] = 16'h0C00;
    seq[3] = 16'h0105; seq[4] = 16'h1A3F; seq[5] = 16'h1B40;
    for (int i = 0; i < n; i++) exp_q.push_back({7'h74, seq[i]});
  endtask

  task automatic do_start();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_stray();
    @(negedge clk); stray_done = 1'b1; stray_nack = 1'b1;
    @(negedge clk); stray_done = 1'b0; stray_nack = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {mem_rd_o, mem_addr_o, txn_valid_o, txn_addr_o, txn_reg_o, txn_data_o,
            busy_o, done_o, err_o, err_idx_o};
  endfunction

  task automatic test_reset();
    arstn_i = 1'b0; start_i = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (all_outs() !== 32'd0) begin
      tests_failed++; $display("FAIL reset_outs: got %h required 0", all_outs());
    end
    arstn_i = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (all_outs() !== 32'd0) begin
      tests_failed++; $display("FAIL reset_release_outs: got %h required 0", all_outs());
    end
  endtask

  task automatic test_stray_idle();
    int a0 = acc_cnt;
    pulse_stray();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy_o, done_o, err_o, txn_valid_o} !== 4'b0 || acc_cnt != a0) begin
      tests_failed++;
      $display("FAIL stray_idle: got b%0b d%0b e%0b v%0b acc%0d required 0 0 0 0 acc%0d",
               busy_o, done_o, err_o, txn_valid_o, acc_cnt, a0);
    end
  endtask

  task automatic test_full_load();
    bit ok; int a0 = acc_cnt;
    push_seq(6);
    do_start();
    tests_run++;
    if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL busy_after_start: got %b required 1", busy_o); end
    wait_idle(2000, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL full_timeout: got busy required idle"); end
    tests_run++;
    if ({done_o, err_o, busy_o} !== 3'b100) begin
      tests_failed++; $display("FAIL full_status: got %b required 100", {done_o, err_o, busy_o});
    end
    tests_run++;
    if (exp_q.size() != 0 || acc_cnt - a0 != 6) begin
      tests_failed++; $display("FAIL full_count: got %0d left %0d acc required 0 left 6 acc", exp_q.size(), acc_cnt - a0);
      exp_q.delete();
    end
  endtask

  task automatic test_stray_done();
    pulse_stray();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({done_o, err_o, busy_o} !== 3'b100) begin
      tests_failed++; $display("FAIL stray_done_state: got %b required 100", {done_o, err_o, busy_o});
    end
  endtask

  task automatic test_pause_timing();
    bit ok; int t0 = -1; int t1 = -1; int vip = 0;
    push_seq(6);
    do_start();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (t0 < 0) begin
        if (txn_done_i && last_acc == 16'h0C00) t0 = cyc;
      end else begin
        if (txn_valid_o) vip++;
        if (mem_rd_o) begin t1 = cyc; break; end
      end
    end
    tests_run++;
    if (t0 < 0 || t1 < 0 || t1 - t0 != PAUSE_CYCLES + 2) begin
      tests_failed++; $display("FAIL pause_len: got %0d required %0d", t1 - t0, PAUSE_CYCLES + 2);
    end
    tests_run++;
    if (vip != 0) begin tests_failed++; $display("FAIL pause_quiet: got %0d valid cycles required 0", vip); end
    wait_idle(2000, ok);
    tests_run++;
    if (!ok || done_o !== 1'b1 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL pause_done: got ok%0b done%b left%0d required 1 1 0", ok, done_o, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_ready_hold();
    bit ok; int a0 = acc_cnt;
    ready_delay = 20;
    push_seq(6);
    do_start();
    wait_idle(4000, ok);
    ready_delay = 0;
    tests_run++;
    if (!ok || done_o !== 1'b1 || exp_q.size() != 0 || acc_cnt - a0 != 6) begin
      tests_failed++;
      $display("FAIL ready_hold: got ok%0b done%b left%0d acc%0d required 1 1 0 6", ok, done_o, exp_q.size(), acc_cnt - a0);
      exp_q.delete();
    end
  endtask

  task automatic test_nack();
    bit ok; int a0;
    nack_en = 1'b1; nack_match = 16'h1A3F;
    push_seq(5);
    do_start();
    wait_idle(2000, ok);
    tests_run++;
    if (!ok || {err_o, done_o, busy_o} !== 3'b100) begin
      tests_failed++; $display("FAIL nack_status: got ok%0b %b required 1 100", ok, {err_o, done_o, busy_o});
    end
    tests_run++;
    if (err_idx_o !== 2'd2) begin tests_failed++; $display("FAIL nack_idx: got %0d required 2", err_idx_o); end
    a0 = acc_cnt;
    repeat (40) @(negedge clk);
    tests_run++;
    if (acc_cnt != a0 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL nack_quiet: got %0d extra left%0d required 0 0", acc_cnt - a0, exp_q.size());
      exp_q.delete();
    end
    nack_en = 1'b0;
    push_seq(6);
    do_start();
    wait_idle(2000, ok);
    tests_run++;
    if (!ok || {done_o, err_o} !== 2'b10 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL nack_reload: got ok%0b %b left%0d required 1 10 0", ok, {done_o, err_o}, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_in_pause();
    bit ok; bit seen = 1'b0;
    push_seq(6);
    do_start();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txn_done_i && last_acc == 16'h0C00) begin seen = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
    arstn_i = 1'b0;
    #1;
    tests_run++;
    if (!seen || all_outs() !== 32'd0) begin
      tests_failed++; $display("FAIL rst_pause_outs: got seen%0b %h required 1 0", seen, all_outs());
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk);
    push_seq(6);
    do_start();
    wait_idle(2000, ok);
    tests_run++;
    if (!ok || done_o !== 1'b1 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL rst_restart: got ok%0b done%b left%0d required 1 1 0", ok, done_o, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_start_busy();
    bit ok; int a0 = acc_cnt;
    push_seq(6);
    do_start();
    repeat (5) @(negedge clk);
    do_start();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txn_done_i && last_acc == 16'h0C00) break;
    end
    repeat (3) @(negedge clk);
    do_start();
    wait_idle(2000, ok);
    tests_run++;
    if (!ok || done_o !== 1'b1 || exp_q.size() != 0 || acc_cnt - a0 != 6) begin
      tests_failed++;
      $display("FAIL start_busy: got ok%0b done%b left%0d acc%0d required 1 1 0 6", ok, done_o, exp_q.size(), acc_cnt - a0);
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_stray_idle();
    test_full_load();
    test_stray_done();
    test_pause_timing();
    test_ready_hold();
    test_nack();
    test_reset_in_pause();
    test_start_busy();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
